pe_acc_stream: RTL

Parametrised, pipelined successor to the fixed 6x6 processing element. It takes a stream of one ARRAY_DIM x ARRAY_DIM image window plus the matching weight window per beat, and multiplies and reduces the masked KxK region. Partial sums are accumulated across input channels in an internal accumulator. At the last channel it applies bias, arithmetic shift, saturation and optional ReLU. The result leaves on a valid/ready output, so psums no longer round-trip through external psum memories.

---
 rtl/pe_acc_stream.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_acc_stream.sv
// Pipelined masked KxK multiply-reduce PE with a cross-channel accumulator, bias/shift/saturate output stage.
// Optional build macro: PE_RELU_EN makes i_relu functional (clamp negative results to 0).
module pe_acc_stream #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ARRAY_DIM   = 6,
    parameter int unsigned CH_WIDTH    = 6,
    parameter int unsigned SHIFT_WIDTH = 4
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic                                    i_clr,
    input  logic                                    i_in_valid,
    output logic                                    o_in_ready,
    input  logic [DATA_WIDTH*ARRAY_DIM*ARRAY_DIM-1:0] i_img,
    input  logic [DATA_WIDTH*ARRAY_DIM*ARRAY_DIM-1:0] i_wgt,
    input  logic                                    i_last,
    input  logic [2:0]                              i_ksize,
    input  logic [SHIFT_WIDTH-1:0]                  i_shift,
    input  logic [DATA_WIDTH-1:0]                   i_bias,
    input  logic                                    i_relu,
    output logic                                    o_out_valid,
    input  logic                                    i_out_ready,
    output logic [DATA_WIDTH-1:0]                   o_out_data,
    output logic                                    o_busy,
    output logic                                    o_err
);

    localparam int unsigned NUM_ELEM   = ARRAY_DIM * ARRAY_DIM;
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned PSUM_WIDTH = 2 * DATA_WIDTH + $clog2(NUM_ELEM);
    localparam int unsigned ACC_WIDTH  = PSUM_WIDTH + CH_WIDTH + 1;
    localparam int unsigned CNT_WIDTH  = CH_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(1 << CH_WIDTH);

    typedef enum logic [0:0] {ST_IDLE, ST_ACC} state_t;

    state_t                       r_state, w_state_next;
    logic                         w_en, w_accept, w_first;
    logic [2:0]                   w_ksel;
    logic signed [PSUM_WIDTH-1:0] w_psum;

    logic                         r_v1, r_l1;
    logic signed [PSUM_WIDTH-1:0] r_psum;
    logic [2:0]                   r_ksize;
    logic [SHIFT_WIDTH-1:0]       r_shift;
    logic signed [DATA_WIDTH-1:0] r_bias;

    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_acc_empty;
    logic                         r_out_valid;
    logic [DATA_WIDTH-1:0]        r_out_data;

    logic [CNT_WIDTH-1:0]         r_cnt, w_cnt_inc;
    logic                         r_err;

    logic signed [ACC_WIDTH-1:0]  w_bias_ext, w_base, w_acc_next, w_shifted;
    logic [ACC_WIDTH-DATA_WIDTH:0] w_upper;
    logic [DATA_WIDTH-1:0]        w_sat, w_result;

    assign w_en       = !r_out_valid || i_out_ready;
    assign o_in_ready = w_en;
    assign w_accept   = i_in_valid && w_en && !i_clr;
    assign w_first    = (r_state == ST_IDLE);
    // First beat of a group uses live ksize; later beats use the group copy.
    assign w_ksel     = w_first ? i_ksize : r_ksize;

    // Masked multiply-reduce over the KxK corner of the window.
    always_comb begin : psum_calc
        logic signed [DATA_WIDTH-1:0] a, b;
        logic signed [PROD_WIDTH-1:0] p;
        int unsigned                  k;
        w_psum = '0;
        a      = '0;
        b      = '0;
        p      = '0;
        if (w_ksel == 3'd0 || 32'(w_ksel) > ARRAY_DIM) k = ARRAY_DIM;
        else                                           k = 32'(w_ksel);
        for (int unsigned r = 0; r < ARRAY_DIM; r++) begin
            for (int unsigned c = 0; c < ARRAY_DIM; c++) begin
                a = signed'(i_img[(r*ARRAY_DIM+c)*DATA_WIDTH +: DATA_WIDTH]);
                b = signed'(i_wgt[(r*ARRAY_DIM+c)*DATA_WIDTH +: DATA_WIDTH]);
                p = a * b;
                if (r < k && c < k) w_psum = w_psum + PSUM_WIDTH'(p);
            end
        end
    end

    // Stage 1 and group configuration capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1    <= 1'b0;
            r_l1    <= 1'b0;
            r_psum  <= '0;
            r_ksize <= '0;
            r_shift <= '0;
            r_bias  <= '0;
        end else if (i_clr) begin
            r_v1 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_psum <= w_psum;
                r_l1   <= i_last;
            end
            if (w_accept && w_first) begin
                r_ksize <= i_ksize;
                r_shift <= i_shift;
                r_bias  <= signed'(i_bias);
            end
        end
    end

    // Stage 2 datapath: bias seed, accumulate, floor shift, saturate.
    assign w_bias_ext = ACC_WIDTH'(r_bias);
    assign w_base     = r_acc_empty ? (w_bias_ext <<< r_shift) : r_acc;
    assign w_acc_next = w_base + ACC_WIDTH'(r_psum);
    assign w_shifted  = w_acc_next >>> r_shift;
    assign w_upper    = w_shifted[ACC_WIDTH-1:DATA_WIDTH-1];

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (!w_shifted[ACC_WIDTH-1] && (|w_upper))
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (w_shifted[ACC_WIDTH-1] && !(&w_upper))
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end

`ifdef PE_RELU_EN
    logic r_relu;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                            r_relu <= 1'b0;
        else if (!i_clr && w_accept && w_first)  r_relu <= i_relu;
    end

    assign w_result = (r_relu && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
`else
    logic w_unused_relu;
    assign w_unused_relu = i_relu;
    assign w_result      = w_sat;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc       <= '0;
            r_acc_empty <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (i_clr) begin
            r_acc       <= '0;
            r_acc_empty <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_v1 && r_l1;
            if (r_v1) begin
                if (r_l1) begin
                    r_out_data  <= w_result;
                    r_acc       <= '0;
                    r_acc_empty <= 1'b1;
                end else begin
                    r_acc       <= w_acc_next;
                    r_acc_empty <= 1'b0;
                end
            end
        end
    end

    // Beat counter saturates so a runaway group cannot wrap and clear o_err logic.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= i_last ? '0 : w_cnt_inc;
            if (!i_last && w_cnt_inc > CNT_LIMIT) r_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (i_clr) begin
            w_state_next = ST_IDLE;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: w_state_next = i_last ? ST_IDLE : ST_ACC;
                ST_ACC:  w_state_next = i_last ? ST_IDLE : ST_ACC;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_err       = r_err;
    assign o_busy      = (r_state == ST_ACC) || r_v1 || r_out_valid;

endmodule
